ifetch_idecode_queue: RTL and testbench

Parametrised fetch-to-decode pipeline buffer. It replaces the single-entry IF/ID latch with a DEPTH-entry queue of fetch bundles, each LANES instructions wide. It decouples instruction-cache hits from decode stalls and supports a synchronous flush for branch and jump redirects. It sits between the fetch stage (PC, icache) and the decode stage of the pipelined datapath.

---
 rtl/ifetch_idecode_queue_pkg.sv | 33 +++
 rtl/ifetch_idecode_queue_fd_queue_ctrl.sv | 75 +++++++
 rtl/ifetch_idecode_queue.sv | 121 ++++++++++++
 tb/tb_ifetch_idecode_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_idecode_queue_pkg.sv
// ============================================================================
//  Module      : ifetch_idecode_queue_pkg
//  Description : Shared types and constants for the fetch-to-decode queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ifetch_idecode_queue_pkg;

    typedef logic [31:0] word_t;

    // sll $0,$0,0 encodes as all zeros; decode treats it as a bubble
    localparam word_t       NOP_INSTR    = 32'h0;
    localparam int unsigned FD_LANES_MAX = 4;

    // One fetch bundle as stored in the queue; lanes above LANES stay zero
    typedef struct packed {
        word_t [FD_LANES_MAX-1:0] instr;
        logic  [FD_LANES_MAX-1:0] lane_valid;
        word_t                    pc;
        word_t                    pcplusfour;
    } fd_entry_t;

    localparam fd_entry_t FD_ENTRY_EMPTY = '0;

    // Instruction stored for one lane: invalid lanes are squashed to NOP
    function automatic word_t lane_instr(input word_t instr, input logic valid);
        return valid ? instr : NOP_INSTR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_idecode_queue_fd_queue_ctrl.sv
// ============================================================================
//  Module      : fd_queue_ctrl
//  Description : Pointer, occupancy and full/empty control for the
//                fetch-to-decode queue. Resolves flush > enqueue/dequeue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fd_queue_ctrl
    import ifetch_idecode_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             bundle_nonempty,
    input  logic             deq,
    input  logic             flush,
    output logic             enq_fire,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic deq_fire;

    // Handshake qualification; full/empty come from registered count only,
    // so deq never opens a same-cycle slot for fetch
    always_comb begin
        enq_fire = ihit && !full && !flush && bundle_nonempty;
        deq_fire = deq && !empty && !flush;
    end

    // Status derived purely from the occupancy register
    always_comb begin
        full  = (count == DEPTH_CNT);
        empty = (count == '0);
    end

    // Pointer and occupancy state; flush wins over any concurrent traffic
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq_fire && !deq_fire) begin
                count <= count + CNT_W'(1);
            end else if (deq_fire && !enq_fire) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_idecode_queue.sv
// ============================================================================
//  Module      : ifetch_idecode_queue
//  Description : DEPTH-entry queue of LANES-wide fetch bundles between the
//                fetch and decode stages. Head entry drives the outputs;
//                an empty queue presents a NOP bubble.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_idecode_queue
    import ifetch_idecode_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LANES = 1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       ihit,
    input  logic [LANES*32-1:0]        instr_in,
    input  logic [LANES-1:0]           lane_valid_in,
    input  logic [31:0]                pc_in,
    input  logic [31:0]                pcplusfour_in,
    input  logic                       deq,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       valid_out,
    output logic [LANES*32-1:0]        instr_out,
    output logic [LANES-1:0]           lane_valid_out,
    output logic [31:0]                pc_out,
    output logic [31:0]                pcplusfour_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                        enq_fire;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    fd_entry_t                   entries [DEPTH];
    fd_entry_t                   wr_entry;
    fd_entry_t                   head;
    word_t [FD_LANES_MAX-1:0]    wr_instr;
    logic  [FD_LANES_MAX-1:0]    wr_mask;

    fd_queue_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .CLK             (CLK),
        .nRST            (nRST),
        .ihit            (ihit),
        .bundle_nonempty (|lane_valid_in),
        .deq             (deq),
        .flush           (flush),
        .enq_fire        (enq_fire),
        .wr_ptr          (wr_ptr),
        .rd_ptr          (rd_ptr),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    // Build the incoming entry lane by lane; lanes beyond LANES are tied off
    generate
        for (genvar l = 0; l < FD_LANES_MAX; l++) begin : g_wr_lane
            if (l < LANES) begin : g_used
                assign wr_instr[l] = lane_instr(instr_in[l*32 +: 32], lane_valid_in[l]);
                assign wr_mask[l]  = lane_valid_in[l];
            end else begin : g_unused
                assign wr_instr[l] = NOP_INSTR;
                assign wr_mask[l]  = 1'b0;
            end
        end
    endgenerate

    // Pack the write-side fields into one queue entry
    always_comb begin
        wr_entry            = FD_ENTRY_EMPTY;
        wr_entry.instr      = wr_instr;
        wr_entry.lane_valid = wr_mask;
        wr_entry.pc         = pc_in;
        wr_entry.pcplusfour = pcplusfour_in;
    end

    // Entry storage; reset clears every slot, flush only moves pointers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= FD_ENTRY_EMPTY;
            end
        end else if (enq_fire) begin
            entries[wr_ptr] <= wr_entry;
        end
    end

    // Head selection with bubble substitution; depends only on registers
    always_comb begin
        head      = empty ? FD_ENTRY_EMPTY : entries[rd_ptr];
        valid_out = !empty;
    end

    // Present the head lanes on the flat output buses
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_rd_lane
            assign instr_out[l*32 +: 32] = head.instr[l];
            assign lane_valid_out[l]     = head.lane_valid[l];
        end
    endgenerate

    // Head PCs, already zeroed for the bubble case
    always_comb begin
        pc_out         = head.pc;
        pcplusfour_out = head.pcplusfour;
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_idecode_queue.sv
// ============================================================================
//  Module      : tb_ifetch_idecode_queue
//  Description : Scoreboard bench for the fetch-to-decode queue
//                (DEPTH=2, LANES=2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifetch_idecode_queue;

    localparam int DEPTH = 2;
    localparam int LANES = 2;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic                  ihit;
    logic [LANES*32-1:0]   instr_in;
    logic [LANES-1:0]      lane_valid_in;
    logic [31:0]           pc_in;
    logic [31:0]           pcplusfour_in;
    logic                  deq;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic [$clog2(DEPTH):0] count;
    logic                  valid_out;
    logic [LANES*32-1:0]   instr_out;
    logic [LANES-1:0]      lane_valid_out;
    logic [31:0]           pc_out;
    logic [31:0]           pcplusfour_out;

    typedef struct packed {
        logic [63:0] instr;
        logic [1:0]  lv;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    ifetch_idecode_queue #(
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .instr_in       (instr_in),
        .lane_valid_in  (lane_valid_in),
        .pc_in          (pc_in),
        .pcplusfour_in  (pcplusfour_in),
        .deq            (deq),
        .flush          (flush),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .valid_out      (valid_out),
        .instr_out      (instr_out),
        .lane_valid_out (lane_valid_out),
        .pc_out         (pc_out),
        .pcplusfour_out (pcplusfour_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; acc marks a bundle the queue must retain
    task automatic step(input logic ih, input logic [1:0] m,
                        input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] i1, input logic [31:0] i0,
                        input logic dq, input logic fl, input bit acc);
        exp_t e;
        ihit          = ih;
        lane_valid_in = m;
        pc_in         = pc;
        pcplusfour_in = pc4;
        instr_in      = {i1, i0};
        deq           = dq;
        flush         = fl;
        if (fl) sb.delete();
        if (acc) begin
            e.instr = {(m[1] ? i1 : 32'h0), (m[0] ? i0 : 32'h0)};
            e.lv    = m;
            e.pc    = pc;
            e.pc4   = pc4;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic dq);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, dq, 1'b0, 1'b0);
    endtask

    // Monitor: every head consumed by decode is compared against the scoreboard
    always @(negedge CLK) begin
        if (nRST && valid_out && deq && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_deq: got pc %0h expected no entry", pc_out);
            end else begin
                mon_e = sb.pop_front();
                check("head_pc",    {32'h0, pc_out},         {32'h0, mon_e.pc});
                check("head_pc4",   {32'h0, pcplusfour_out}, {32'h0, mon_e.pc4});
                check("head_instr", instr_out,               mon_e.instr);
                check("head_mask",  {62'h0, lane_valid_out}, {62'h0, mon_e.lv});
            end
        end
    end

    initial begin
        nRST = 1'b0;
        ihit = 1'b0; lane_valid_in = '0; pc_in = '0; pcplusfour_in = '0;
        instr_in = '0; deq = 1'b0; flush = 1'b0;
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full",  64'(full),  64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_instr", instr_out, 64'h0);
        check("rst_pc",    64'(pc_out), 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle(1'b0);

        // Fill and drain: third bundle arrives while full and is dropped
        step(1'b1, 2'b01, 32'h0, 32'h4, 32'h0, 32'h11, 1'b0, 1'b0, 1'b1);
        check("fill1_count", 64'(count), 64'd1);
        check("fill1_pc",    64'(pc_out), 64'h0);
        step(1'b1, 2'b01, 32'h4, 32'h8, 32'h0, 32'h22, 1'b0, 1'b0, 1'b1);
        check("fill2_full",  64'(full),  64'd1);
        check("fill2_count", 64'(count), 64'd2);
        step(1'b1, 2'b01, 32'h8, 32'hC, 32'h0, 32'h33, 1'b0, 1'b0, 1'b0);
        check("fill3_count", 64'(count), 64'd2);
        idle(1'b1);
        check("drain1_pc", 64'(pc_out), 64'h4);
        idle(1'b1);
        check("drain_empty", 64'(empty),     64'd1);
        check("drain_valid", 64'(valid_out), 64'd0);
        check("drain_pc",    64'(pc_out),    64'd0);
        check("drain_instr", instr_out,      64'h0);

        // Simultaneous enqueue and dequeue at count=1, pointers wrap
        step(1'b1, 2'b01, 32'h100, 32'h104, 32'h0, 32'hA0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 2'b01, 32'h100 + 32'(4*k), 32'h104 + 32'(4*k),
                 32'h0, 32'hA0 + 32'(k), 1'b1, 1'b0, 1'b1);
            check("sim_count", 64'(count),  64'd1);
            check("sim_pc",    64'(pc_out), 64'(32'h100 + 32'(4*k)));
        end
        idle(1'b1);
        check("sim_empty", 64'(empty), 64'd1);

        // Flush with a concurrent ihit: bundle dropped, refetch one cycle later
        step(1'b1, 2'b01, 32'h200, 32'h204, 32'h0, 32'hB0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b01, 32'h204, 32'h208, 32'h0, 32'hB1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b01, 32'h40, 32'h44, 32'h0, 32'hF0, 1'b0, 1'b1, 1'b0);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_count", 64'(count), 64'd0);
        step(1'b1, 2'b01, 32'h40, 32'h44, 32'h0, 32'hF0, 1'b0, 1'b0, 1'b1);
        check("refetch_valid", 64'(valid_out), 64'd1);
        check("refetch_pc",    64'(pc_out),    64'h40);
        idle(1'b1);

        // Partial bundle squashes lane 1; an all-invalid mask is not stored
        step(1'b1, 2'b01, 32'h300, 32'h304, 32'hDEADBEEF, 32'h20080001, 1'b0, 1'b0, 1'b1);
        check("part_lane1", {32'h0, instr_out[63:32]}, 64'h0);
        check("part_lane0", {32'h0, instr_out[31:0]},  64'h20080001);
        check("part_mask",  64'(lane_valid_out),       64'd1);
        step(1'b1, 2'b00, 32'h400, 32'h408, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0);
        check("mask0_count", 64'(count), 64'd1);
        step(1'b1, 2'b11, 32'h500, 32'h508, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1);
        check("two_lane_full", 64'(full), 64'd1);
        idle(1'b1);
        idle(1'b1);
        check("part_empty", 64'(empty), 64'd1);

        // deq on empty is ignored
        idle(1'b1);
        check("deq_empty_count", 64'(count), 64'd0);
        check("deq_empty_empty", 64'(empty), 64'd1);

        // Full with deq and ihit: no same-cycle slot, ihit bundle dropped
        step(1'b1, 2'b01, 32'h600, 32'h604, 32'h0, 32'hC0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b01, 32'h604, 32'h608, 32'h0, 32'hC1, 1'b0, 1'b0, 1'b1);
        check("fdq_full", 64'(full), 64'd1);
        step(1'b1, 2'b01, 32'h608, 32'h60C, 32'h0, 32'hC2, 1'b1, 1'b0, 1'b0);
        check("fdq_count", 64'(count), 64'd1);
        check("fdq_nfull", 64'(full),  64'd0);
        idle(1'b1);
        check("fdq_empty", 64'(empty), 64'd1);

        // Asynchronous reset mid-stream, checked before any further edge
        step(1'b1, 2'b01, 32'h700, 32'h704, 32'h0, 32'hD0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b01, 32'h704, 32'h708, 32'h0, 32'hD1, 1'b0, 1'b0, 1'b1);
        ihit = 1'b0; lane_valid_in = '0; deq = 1'b0;
        check("pre_rst_count", 64'(count), 64'd2);
        #3;
        nRST = 1'b0;
        sb.delete();
        #1;
        check("arst_count", 64'(count),     64'd0);
        check("arst_empty", 64'(empty),     64'd1);
        check("arst_full",  64'(full),      64'd0);
        check("arst_valid", 64'(valid_out), 64'd0);
        check("arst_instr", instr_out,      64'h0);
        check("arst_pc",    64'(pc_out),    64'd0);
        check("arst_pc4",   64'(pcplusfour_out), 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle(1'b0);
        check("post_rst_empty", 64'(empty), 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
